// File: rtl/rst_seq_defs.sv
// rst_seq_defs: shared state encoding and widths
// for the reset sequencer slice.
package rst_seq_defs;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam int IDX_W = 4;

endpackage

// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: request/ready inputs and
// per-domain reset/status outputs of the sequencer.
interface rst_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  import rst_seq_defs::*;

  logic                   in_sw_reset_req;
  logic [NUM_DOMAINS-1:0] in_domain_ready;
  logic [NUM_DOMAINS-1:0] out_domain_reset;
  logic                   out_all_released;
  logic                   out_busy;
  logic                   out_fault;
  logic [IDX_W-1:0]       out_fault_idx;

  modport master (
    input  in_sw_reset_req,
    input  in_domain_ready,
    output out_domain_reset,
    output out_all_released,
    output out_busy,
    output out_fault,
    output out_fault_idx
  );

  modport slave (
    output in_sw_reset_req,
    output in_domain_ready,
    input  out_domain_reset,
    input  out_all_released,
    input  out_busy,
    input  out_fault,
    input  out_fault_idx
  );

endinterface

// File: rtl/rst_seq_timer.sv
// rst_seq_timer: up-counter with sync clear and
// a compare against a caller-supplied terminal.
module rst_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] count,
  output logic             match
);

  // count up; exits of the owning FSM keep it below wrap
  always_ff @(posedge in_clk) begin
    if (in_reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign match = (count == terminal);

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: holds all domains in reset, then
// releases them in index order gated by spacing/ready.
module rst_sequencer
  import rst_seq_defs::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STEP_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input logic             in_clk,
  input logic             in_reset,
  rst_sequencer_if.master bus
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_DOMAINS - 1);
  localparam logic [CNT_W-1:0] HOLD_T =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_T =
    CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_T =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   fault_q, fault_d;
  logic [IDX_W-1:0]       fidx_q, fidx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   tmr_clr;
  logic                   tmr_inc;
  logic [CNT_W-1:0]       tmr_term;
  logic [CNT_W-1:0]       tmr_cnt;
  logic                   tmr_match;
  logic                   rdy_sel;
  logic                   step_ok;

  // HOLD counts to the hold length, RELEASE to timeout
  assign tmr_term = (state_q == ST_HOLD) ? HOLD_T
                                         : TOUT_T;
  assign step_ok  = (tmr_cnt >= STEP_T);

  rst_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .in_clk   (in_clk),
    .in_reset (in_reset),
    .clear    (tmr_clr),
    .inc      (tmr_inc),
    .terminal (tmr_term),
    .count    (tmr_cnt),
    .match    (tmr_match)
  );

  // select the ready ack of the domain being waited on
  always_comb begin
    rdy_sel = 1'b0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (i == int'(idx_q)) begin
        rdy_sel = bus.in_domain_ready[i];
      end
    end
  end

  // state register; in_reset re-holds every domain
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q <= ST_HOLD;
      idx_q   <= '0;
      rst_q   <= '1;
      fault_q <= 1'b0;
      fidx_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      fault_q <= fault_d;
      fidx_q  <= fidx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // next state; a sw request beats any FSM progress
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    fault_d = fault_q;
    fidx_d  = fidx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    if (bus.in_sw_reset_req) begin
      state_d = ST_HOLD;
      idx_d   = '0;
      rst_d   = '1;
      fault_d = 1'b0;
      fidx_d  = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (tmr_match) begin
            state_d  = ST_RELEASE;
            rst_d[0] = 1'b0;
            tmr_clr  = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (step_ok && rdy_sel) begin
            tmr_clr = 1'b1;
            if (idx_q == LAST) begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              for (int i = 0; i < NUM_DOMAINS; i++) begin
                if (i == int'(idx_q) + 1) begin
                  rst_d[i] = 1'b0;
                end
              end
            end
          end else if (tmr_match) begin
            state_d = ST_FAULT;
            rst_d   = '1;
            fault_d = 1'b1;
            fidx_d  = idx_q;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            tmr_clr = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  assign bus.out_domain_reset = rst_q;
  assign bus.out_all_released = done_q;
  assign bus.out_busy         = busy_q;
  assign bus.out_fault        = fault_q;
  assign bus.out_fault_idx    = fidx_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed scenarios for the
// reset sequencer (4-domain and 1-domain builds).
module tb_rst_sequencer;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  rst_sequencer_if #(.NUM_DOMAINS(4)) bus4 ();
  rst_sequencer_if #(.NUM_DOMAINS(1)) bus1 ();

  rst_sequencer #(
    .NUM_DOMAINS    (4),
    .HOLD_CYCLES    (16),
    .STEP_CYCLES    (8),
    .TIMEOUT_CYCLES (64),
    .CNT_W          (8)
  ) dut4 (
    .in_clk   (clk),
    .in_reset (rst),
    .bus      (bus4)
  );

  rst_sequencer #(
    .NUM_DOMAINS    (1),
    .HOLD_CYCLES    (16),
    .STEP_CYCLES    (8),
    .TIMEOUT_CYCLES (64),
    .CNT_W          (8)
  ) dut1 (
    .in_clk   (clk),
    .in_reset (rst),
    .bus      (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc==N while observing the value "at cycle N"
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic at(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cycle got=%0d want=%0d", cyc, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus4.in_sw_reset_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_req();
    bus4.in_sw_reset_req = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_sw_reset_req = 1'b0;
  endtask

  task automatic test_reset();
    bus4.in_domain_ready = 4'b1111;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_vec got=%b want=1111",
               bus4.out_domain_reset);
    end
    n_checks++;
    if (bus4.out_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy got=%b want=1",
               bus4.out_busy);
    end
    n_checks++;
    if (bus4.out_all_released !== 1'b0 ||
        bus4.out_fault !== 1'b0 ||
        bus4.out_fault_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b%b%0d want=000",
               bus4.out_all_released, bus4.out_fault,
               bus4.out_fault_idx);
    end
    n_checks++;
    if (bus1.out_domain_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_vec1 got=%b want=1",
               bus1.out_domain_reset);
    end
  endtask

  task automatic test_power_on();
    bus4.in_domain_ready = 4'b1111;
    do_reset();
    at(15);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1111) begin
      n_fail++;
      $display("FAIL po_c15 got=%b want=1111",
               bus4.out_domain_reset);
    end
    at(16);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1110) begin
      n_fail++;
      $display("FAIL po_c16 got=%b want=1110",
               bus4.out_domain_reset);
    end
    at(23);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1110) begin
      n_fail++;
      $display("FAIL po_c23 got=%b want=1110",
               bus4.out_domain_reset);
    end
    n_checks++;
    if (bus1.out_all_released !== 1'b0) begin
      n_fail++;
      $display("FAIL nd1_c23 got=%b want=0",
               bus1.out_all_released);
    end
    at(24);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1100) begin
      n_fail++;
      $display("FAIL po_c24 got=%b want=1100",
               bus4.out_domain_reset);
    end
    n_checks++;
    if (bus1.out_all_released !== 1'b1 ||
        bus1.out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nd1_done got=%b%b want=10",
               bus1.out_all_released, bus1.out_busy);
    end
    at(32);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1000) begin
      n_fail++;
      $display("FAIL po_c32 got=%b want=1000",
               bus4.out_domain_reset);
    end
    at(40);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b0000) begin
      n_fail++;
      $display("FAIL po_c40 got=%b want=0000",
               bus4.out_domain_reset);
    end
    at(47);
    n_checks++;
    if (bus4.out_all_released !== 1'b0 ||
        bus4.out_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL po_c47 got=%b%b want=01",
               bus4.out_all_released, bus4.out_busy);
    end
    at(48);
    n_checks++;
    if (bus4.out_all_released !== 1'b1 ||
        bus4.out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL po_done got=%b%b want=10",
               bus4.out_all_released, bus4.out_busy);
    end
    at(50);
    bus4.in_domain_ready = 4'b0000;
    at(53);
    n_checks++;
    if (bus4.out_all_released !== 1'b1 ||
        bus4.out_domain_reset !== 4'b0000) begin
      n_fail++;
      $display("FAIL done_hold got=%b/%b want=1/0000",
               bus4.out_all_released,
               bus4.out_domain_reset);
    end
  endtask

  task automatic test_reset_in_done();
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1111 ||
        bus4.out_all_released !== 1'b0 ||
        bus4.out_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_done got=%b%b%b want=111100",
               bus4.out_domain_reset,
               bus4.out_all_released, bus4.out_fault);
    end
    rst = 1'b0;
  endtask

  task automatic test_slow_ready();
    bus4.in_domain_ready = 4'b1011;
    do_reset();
    at(32);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1000) begin
      n_fail++;
      $display("FAIL slow_c32 got=%b want=1000",
               bus4.out_domain_reset);
    end
    at(50);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1000) begin
      n_fail++;
      $display("FAIL slow_c50 got=%b want=1000",
               bus4.out_domain_reset);
    end
    bus4.in_domain_ready = 4'b1111;
    at(51);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b0000) begin
      n_fail++;
      $display("FAIL slow_c51 got=%b want=0000",
               bus4.out_domain_reset);
    end
    at(58);
    n_checks++;
    if (bus4.out_all_released !== 1'b0) begin
      n_fail++;
      $display("FAIL slow_c58 got=%b want=0",
               bus4.out_all_released);
    end
    at(59);
    n_checks++;
    if (bus4.out_all_released !== 1'b1) begin
      n_fail++;
      $display("FAIL slow_c59 got=%b want=1",
               bus4.out_all_released);
    end
  endtask

  task automatic test_timeout();
    bus4.in_domain_ready = 4'b1101;
    do_reset();
    at(24);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1100) begin
      n_fail++;
      $display("FAIL to_c24 got=%b want=1100",
               bus4.out_domain_reset);
    end
    at(87);
    n_checks++;
    if (bus4.out_fault !== 1'b0 ||
        bus4.out_domain_reset !== 4'b1100) begin
      n_fail++;
      $display("FAIL to_c87 got=%b/%b want=0/1100",
               bus4.out_fault, bus4.out_domain_reset);
    end
    at(88);
    n_checks++;
    if (bus4.out_fault !== 1'b1 ||
        bus4.out_fault_idx !== 4'd1 ||
        bus4.out_domain_reset !== 4'b1111 ||
        bus4.out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_fault got=%b/%0d/%b/%b want=1/1/1111/0",
               bus4.out_fault, bus4.out_fault_idx,
               bus4.out_domain_reset, bus4.out_busy);
    end
    at(100);
    n_checks++;
    if (bus4.out_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL to_sticky got=%b want=1",
               bus4.out_fault);
    end
    bus4.in_domain_ready = 4'b1111;
    pulse_req();
    n_checks++;
    if (bus4.out_fault !== 1'b0 ||
        bus4.out_busy !== 1'b1 ||
        bus4.out_domain_reset !== 4'b1111) begin
      n_fail++;
      $display("FAIL to_clear got=%b/%b/%b want=0/1/1111",
               bus4.out_fault, bus4.out_busy,
               bus4.out_domain_reset);
    end
    at(116);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1111) begin
      n_fail++;
      $display("FAIL to_c116 got=%b want=1111",
               bus4.out_domain_reset);
    end
    at(117);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1110) begin
      n_fail++;
      $display("FAIL to_c117 got=%b want=1110",
               bus4.out_domain_reset);
    end
    at(125);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1100) begin
      n_fail++;
      $display("FAIL to_c125 got=%b want=1100",
               bus4.out_domain_reset);
    end
  endtask

  task automatic test_sw_mid();
    bus4.in_domain_ready = 4'b1111;
    do_reset();
    at(30);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1100) begin
      n_fail++;
      $display("FAIL sw_c30 got=%b want=1100",
               bus4.out_domain_reset);
    end
    pulse_req();
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1111 ||
        bus4.out_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_c31 got=%b/%b want=1111/1",
               bus4.out_domain_reset, bus4.out_busy);
    end
    at(46);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1111) begin
      n_fail++;
      $display("FAIL sw_c46 got=%b want=1111",
               bus4.out_domain_reset);
    end
    at(47);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1110) begin
      n_fail++;
      $display("FAIL sw_c47 got=%b want=1110",
               bus4.out_domain_reset);
    end
  endtask

  task automatic test_coincident();
    bus4.in_domain_ready = 4'b1101;
    do_reset();
    at(87);
    pulse_req();
    n_checks++;
    if (bus4.out_fault !== 1'b0 ||
        bus4.out_busy !== 1'b1 ||
        bus4.out_domain_reset !== 4'b1111) begin
      n_fail++;
      $display("FAIL coin_c88 got=%b/%b/%b want=0/1/1111",
               bus4.out_fault, bus4.out_busy,
               bus4.out_domain_reset);
    end
    at(103);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1111 ||
        bus4.out_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL coin_c103 got=%b/%b want=1111/0",
               bus4.out_domain_reset, bus4.out_fault);
    end
    at(104);
    n_checks++;
    if (bus4.out_domain_reset !== 4'b1110) begin
      n_fail++;
      $display("FAIL coin_c104 got=%b want=1110",
               bus4.out_domain_reset);
    end
  endtask

  task automatic test_reset_in_fault();
    bus4.in_domain_ready = 4'b1101;
    do_reset();
    at(88);
    n_checks++;
    if (bus4.out_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL rf_fault got=%b want=1",
               bus4.out_fault);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus4.out_fault !== 1'b0 ||
        bus4.out_fault_idx !== 4'd0 ||
        bus4.out_domain_reset !== 4'b1111 ||
        bus4.out_all_released !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_fault got=%b/%0d/%b/%b want=0/0/1111/0",
               bus4.out_fault, bus4.out_fault_idx,
               bus4.out_domain_reset,
               bus4.out_all_released);
    end
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus4.in_sw_reset_req = 1'b0;
    bus4.in_domain_ready = 4'b1111;
    bus1.in_sw_reset_req = 1'b0;
    bus1.in_domain_ready = 1'b1;
    test_reset();
    test_power_on();
    test_reset_in_done();
    test_slow_ready();
    test_timeout();
    test_sw_mid();
    test_coincident();
    test_reset_in_fault();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
